// File: rtl/alu_result_stage.sv
// Registered result/flag stage behind the 16-bit ALU: a 2-entry skid buffer with a valid/ready handshake.
// Optional sticky overflow accumulator is built when STICKY_OVF_EN is defined.
module alu_result_stage #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 2
) (
    input  logic             CLK,
    input  logic             Reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] alu_result,
    input  logic             alu_c,
    input  logic             alu_v,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             flag_z,
    output logic             flag_n,
    output logic             flag_c,
    output logic             flag_v
`ifdef STICKY_OVF_EN
    ,
    output logic             sticky_v,
    input  logic             clr_sticky
`endif
);

    // The entry layout and count encoding assume exactly two slots.
    if (DEPTH != 2) begin : g_bad_depth
        $error("alu_result_stage supports DEPTH == 2 only");
    end

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } count_t;

    localparam int ENTRY_W = WIDTH + 4;

    count_t count, next_count;
    logic [ENTRY_W-1:0] entry0, entry1;
    logic [ENTRY_W-1:0] new_entry;
    logic push, pop;

    assign in_ready  = (count != FULL);
    assign out_valid = (count != EMPTY);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Flags are frozen into the entry at capture: {data, Z, N, C, V}.
    assign new_entry = {alu_result, (alu_result == '0), alu_result[WIDTH-1], alu_c, alu_v};

    always_ff @(posedge CLK) begin
        if (Reset) begin
            count <= EMPTY;
        end else begin
            count <= next_count;
        end
    end

    always_comb begin
        next_count = count;
        unique case (count)
            EMPTY: begin
                if (push) next_count = ONE;
            end
            ONE: begin
                if (push && !pop)      next_count = FULL;
                else if (!push && pop) next_count = EMPTY;
            end
            FULL: begin
                if (pop) next_count = ONE;
            end
            default: next_count = EMPTY;
        endcase
    end

    // A pop shifts entry1 forward unless a same-cycle push at count one replaces the head directly.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            entry0 <= '0;
            entry1 <= '0;
        end else if (pop) begin
            if (push && count == ONE) begin
                entry0 <= new_entry;
            end else begin
                entry0 <= entry1;
            end
        end else if (push) begin
            if (count == EMPTY) begin
                entry0 <= new_entry;
            end else begin
                entry1 <= new_entry;
            end
        end
    end

    assign result = entry0[ENTRY_W-1:4];
    assign flag_z = entry0[3];
    assign flag_n = entry0[2];
    assign flag_c = entry0[1];
    assign flag_v = entry0[0];

`ifdef STICKY_OVF_EN
    // An overflowing push wins over a same-edge clear.
    always_ff @(posedge CLK) begin
        if (Reset) begin
            sticky_v <= 1'b0;
        end else if (push && alu_v) begin
            sticky_v <= 1'b1;
        end else if (clr_sticky) begin
            sticky_v <= 1'b0;
        end
    end
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Directed self-checking bench for alu_result_stage; sticky overflow steps run only when STICKY_OVF_EN is defined.
module tb_alu_result_stage;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] alu_result;
    logic        alu_c;
    logic        alu_v;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] result;
    logic        flag_z, flag_n, flag_c, flag_v;
`ifdef STICKY_OVF_EN
    logic        sticky_v;
    logic        clr_sticky;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 CLK = ~CLK;

    alu_result_stage #(.WIDTH(16), .DEPTH(2)) dut (
        .CLK        (CLK),
        .Reset      (Reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .alu_result (alu_result),
        .alu_c      (alu_c),
        .alu_v      (alu_v),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .result     (result),
        .flag_z     (flag_z),
        .flag_n     (flag_n),
        .flag_c     (flag_c),
        .flag_v     (flag_v)
`ifdef STICKY_OVF_EN
        ,
        .sticky_v   (sticky_v),
        .clr_sticky (clr_sticky)
`endif
    );

    task automatic applyStimulus(input logic rst, input logic vld, input logic [15:0] data,
                                 input logic c, input logic v, input logic ordy);
        Reset      = rst;
        in_valid   = vld;
        alu_result = data;
        alu_c      = c;
        alu_v      = v;
        out_ready  = ordy;
        @(posedge CLK);
        #1;
    endtask

    // flags_exp is {Z, N, C, V}; with check_data=0 only the handshake signals are compared.
    task automatic checkOutput(input string tag, input logic exp_valid, input logic exp_ready,
                               input logic check_data, input logic [15:0] exp_result,
                               input logic [3:0] flags_exp);
        logic [21:0] obs, exp;
        checks++;
        if (check_data) begin
            obs = {out_valid, in_ready, result, flag_z, flag_n, flag_c, flag_v};
            exp = {exp_valid, exp_ready, exp_result, flags_exp};
        end else begin
            obs = {out_valid, in_ready, 20'h0};
            exp = {exp_valid, exp_ready, 20'h0};
        end
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s: observed valid/ready/result/ZNCV=%h required=%h", tag, obs, exp);
        end
    endtask

`ifdef STICKY_OVF_EN
    task automatic checkSticky(input string tag, input logic exp_sticky);
        checks++;
        assert (sticky_v === exp_sticky) else begin
            failures++;
            $error("[TB] FAIL %s: observed sticky_v=%b required=%b", tag, sticky_v, exp_sticky);
        end
    endtask
`endif

    initial begin
`ifdef STICKY_OVF_EN
        clr_sticky = 1'b0;
`endif
        // Reset dominates a simultaneous valid input
        applyStimulus(1, 1, 16'h1234, 1, 1, 0);
        checkOutput("reset_state", 0, 1, 1, 16'h0000, 4'b0000);
`ifdef STICKY_OVF_EN
        checkSticky("reset_sticky", 0);
`endif

        // SRA result FFFF: negative, nonzero
        applyStimulus(0, 1, 16'hFFFF, 0, 0, 1);
        checkOutput("push_ffff", 1, 1, 1, 16'hFFFF, 4'b0100);

        // Push+pop at count one: zero word replaces head
        applyStimulus(0, 1, 16'h0000, 1, 0, 1);
        checkOutput("push_zero", 1, 1, 1, 16'h0000, 4'b1010);

        applyStimulus(0, 0, 16'h0000, 0, 0, 0);
        checkOutput("stall_stable", 1, 1, 1, 16'h0000, 4'b1010);

        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkOutput("drain_empty", 0, 1, 0, 16'h0000, 4'b0000);

        // Fill to FULL, third word must be refused
        applyStimulus(0, 1, 16'h0001, 0, 0, 0);
        checkOutput("fill_one", 1, 1, 1, 16'h0001, 4'b0000);
        applyStimulus(0, 1, 16'h0002, 0, 0, 0);
        checkOutput("fill_full", 1, 0, 1, 16'h0001, 4'b0000);
        applyStimulus(0, 1, 16'h0003, 0, 0, 0);
        checkOutput("full_refuse", 1, 0, 1, 16'h0001, 4'b0000);
        applyStimulus(0, 1, 16'h0003, 0, 0, 1);
        checkOutput("order_0002", 1, 1, 1, 16'h0002, 4'b0000);
        applyStimulus(0, 1, 16'h0003, 0, 0, 1);
        checkOutput("order_0003", 1, 1, 1, 16'h0003, 4'b0000);
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkOutput("order_empty", 0, 1, 0, 16'h0000, 4'b0000);

        // Simultaneous push and pop with head 0055
        applyStimulus(0, 1, 16'h0055, 0, 0, 0);
        checkOutput("head_0055", 1, 1, 1, 16'h0055, 4'b0000);
        applyStimulus(0, 1, 16'h00AA, 0, 0, 1);
        checkOutput("swap_00aa", 1, 1, 1, 16'h00AA, 4'b0000);
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkOutput("swap_count1", 0, 1, 0, 16'h0000, 4'b0000);

        // Sustained one result per cycle
        for (int i = 0; i < 5; i++) begin
            applyStimulus(0, 1, 16'h8010 + 16'(i), 0, 0, 1);
            checkOutput($sformatf("stream_%0d", i), 1, 1, 1, 16'h8010 + 16'(i), 4'b0100);
        end
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkOutput("stream_drain", 0, 1, 0, 16'h0000, 4'b0000);

`ifdef STICKY_OVF_EN
        applyStimulus(0, 1, 16'h7FFF, 0, 1, 1);
        checkSticky("sticky_set", 1);
        applyStimulus(0, 1, 16'h0010, 0, 0, 1);
        checkSticky("sticky_hold", 1);
        in_valid = 1'b0;
        clr_sticky = 1'b1;
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
        checkSticky("sticky_clear", 0);
        applyStimulus(0, 1, 16'h8000, 1, 1, 1);
        checkSticky("sticky_set_wins", 1);
        clr_sticky = 1'b0;
        applyStimulus(0, 0, 16'h0000, 0, 0, 1);
`endif

        // Reset mid-operation while FULL
        applyStimulus(0, 1, 16'h7777, 0, 0, 0);
        applyStimulus(0, 1, 16'h8888, 0, 0, 0);
        checkOutput("pre_reset_full", 1, 0, 1, 16'h7777, 4'b0000);
        applyStimulus(1, 0, 16'h0000, 0, 0, 0);
        checkOutput("mid_reset", 0, 1, 1, 16'h0000, 4'b0000);
`ifdef STICKY_OVF_EN
        checkSticky("mid_reset_sticky", 0);
`endif

        applyStimulus(0, 1, 16'h4000, 0, 1, 0);
        checkOutput("post_reset_v", 1, 1, 1, 16'h4000, 4'b0001);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_result_stage.md
Name: alu_result_stage

Overview:
- Registered output stage directly downstream of the 16-bit ALU, including its arithmetic right-shift unit.
- Captures the ALU result and computes the Z and N flags at capture time.
- Passes through the adder's C and V flags.
- Presents result and flags to writeback through a valid/ready handshake.
- A 2-entry skid buffer lets the datapath stall without dropping an ALU result.

Parameters:
- WIDTH, 16, datapath width in bits; the flag N is taken from bit WIDTH-1.
- DEPTH, 2, number of buffer entries; only the value 2 is supported.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- Reset  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result valid this cycle.
- in_ready  output  1  stage can accept an entry; equals (count != 2).
- alu_result  input  WIDTH  ALU output word (add/sub/logic/shift).
- alu_c  input  1  carry out from the adder.
- alu_v  input  1  signed overflow from the adder.
- out_valid  output  1  head entry valid.
- out_ready  input  1  writeback consumes head entry this cycle.
- result  output  WIDTH  head entry data.
- flag_z  output  1  head entry zero flag.
- flag_n  output  1  head entry negative flag.
- flag_c  output  1  head entry carry flag.
- flag_v  output  1  head entry overflow flag.
- sticky_v  output  1  accumulated overflow; present only with STICKY_OVF_EN.
- clr_sticky  input  1  clears sticky_v; present only with STICKY_OVF_EN.

Behaviour:
- Reset (synchronous, active-high, dominates everything):
  - count=0; out_valid=0; result=0; all flags=0; sticky_v=0.
  - Buffer entries are cleared.
  - in_valid is ignored during the Reset cycle.
- Handshake:
  - push = in_valid && in_ready.
  - pop = out_valid && out_ready.
  - out_valid = (count != 0).
- Entry contents, computed at push:
  - data = alu_result.
  - Z = (alu_result == 0).
  - N = alu_result[WIDTH-1].
  - C = alu_c; V = alu_v.
  - All flags are stored with the entry, never recomputed at the output.
- Ordering: FIFO. Outputs always show entry 0 (the head). On pop, entry 1 shifts into entry 0.
- Latency: a push at edge k into an empty stage gives out_valid=1 with that data after edge k (1 cycle).
- Count transitions (states EMPTY=0, ONE=1, FULL=2):
  - EMPTY: push -> ONE.
  - ONE: push only -> FULL; pop only -> EMPTY; push and pop together -> ONE, new entry becomes head.
  - FULL: in_ready=0, so no push is possible; pop -> ONE.
- Boundary conditions:
  - Pop when EMPTY is impossible, since out_valid=0.
  - When FULL, in_valid with in_ready=0 is not captured; the upstream stage holds its data.
  - out_ready held high with count=1 and continuous in_valid sustains 1 result per cycle.
  - While out_valid=1 and out_ready=0, result and flags are stable.
  - Reset asserted mid-operation drops all buffered entries; out_valid=0 after that edge.
- Arithmetic: no width changes. Shift results arriving from the ALU are treated as opaque words; the Z/N rules apply to them as to any other result.

Optional Feature:
- Macro: STICKY_OVF_EN.
- When defined:
  - sticky_v is set at any push with alu_v=1.
  - sticky_v is cleared at any edge with clr_sticky=1 and no simultaneous set-push; a set-push wins over clear.
  - Reset clears sticky_v.
  - Ports sticky_v and clr_sticky exist.
- When undefined: both ports are absent and no sticky register is built. All other behaviour is identical.

Test Plan:
- Reset with in_valid=1, alu_result=16'h1234 -> after the edge: out_valid=0, result=0, all flags 0, in_ready=1.
- Push alu_result=16'hFFFF (SRA of FFFF by 1), out_ready=1 -> next cycle: result=FFFF, flag_n=1, flag_z=0, out_valid=1.
- Push 16'h0000 with alu_c=1, alu_v=0 -> flag_z=1, flag_n=0, flag_c=1, flag_v=0.
- out_ready=0; push 16'h0001 then 16'h0002 -> in_ready=0 after the second push. Third in_valid with 16'h0003 is not taken. Then out_ready=1 -> outputs 0001, 0002, 0003 in order with no loss.
- Simultaneous push 16'h00AA and pop with count=1 (head 16'h0055) -> count stays 1, next head=00AA.
- STICKY_OVF_EN defined: push with alu_v=1, then push with alu_v=0 -> sticky_v stays 1. clr_sticky=1 alone -> 0. clr_sticky=1 during a push with alu_v=1 -> sticky_v=1.
